uart_tx_feeder: RTL and testbench

Buffered byte source for the UART transmit path. Accepts bytes from the host-side logic into a synchronous FIFO and presents them one at a time to the UART transmitter using its level-valid / ack handshake (`data`, `data_valid`, `tx_ack`). Releases `data_valid` between bytes so the transmitter sees a fresh rising edge for every byte. Sits directly upstream of the transmitter, in the same clock domain.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_feeder.sv | 130 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: byte type and feeder FSM state.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } feeder_state_t;

  localparam int unsigned BYTE_W   = 8;
  localparam logic [7:0]  DROP_MAX = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush. The read port shows the head combinationally;
// a write into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             wr_drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  // flush dominates a same-cycle write, and such a write is not an overflow
  assign pop     = rd_en && !empty;
  assign push    = wr_en && !flush && (!full || pop);
  assign wr_drop = wr_en && !flush && full && !pop;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered byte source for the UART transmitter (data / data_valid / tx_ack).
// Optional saturating drop counter on port drop_count: UART_TX_FEEDER_DROP_CNT_EN.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  input  logic             flush,
  input  logic             clr_ovf,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic             busy,
  output logic [7:0]       data,
  output logic             data_valid,
  input  logic             tx_ack,
`ifdef UART_TX_FEEDER_DROP_CNT_EN
  output logic [7:0]       drop_count,
`endif
  output logic [1:0]       state_dbg
);

  feeder_state_t state;
  feeder_state_t state_nxt;
  logic          pop;
  logic          wr_drop;
  uart_byte_t    fifo_head;
  uart_byte_t    data_q;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .wr_drop (wr_drop)
  );

  // Handshake: data_valid is a level that stays high with data frozen until
  // tx_ack is seen; it then drops and the next byte is only offered once
  // tx_ack has returned low, so every byte produces a fresh data_valid edge.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_ack) begin
          pop       = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (tx_ack) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!tx_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      data_q <= '0;
    end else if (pop) begin
      data_q <= fifo_head;
    end
  end

  // a drop in the same cycle as a clear leaves the flag set
  always_ff @(posedge clk) begin
    if (!nrst) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_TX_FEEDER_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      drop_cnt_q <= '0;
    end else if (wr_drop) begin
      if (drop_cnt_q != DROP_MAX) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end else if (clr_ovf) begin
      drop_cnt_q <= '0;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  assign data       = data_q;
  assign data_valid = (state == PRESENT);
  assign busy       = (state != IDLE) || !empty;
  assign state_dbg  = state;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder; drop_count checks follow UART_TX_FEEDER_DROP_CNT_EN.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_en = 1'b0;
  logic             flush = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             tx_ack = 1'b0;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             busy;
  logic [7:0]       data;
  logic             data_valid;
  logic [1:0]       state_dbg;
`ifdef UART_TX_FEEDER_DROP_CNT_EN
  logic [7:0]       drop_count;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int w;
  logic [7:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .flush      (flush),
    .clr_ovf    (clr_ovf),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .busy       (busy),
    .data       (data),
    .data_valid (data_valid),
    .tx_ack     (tx_ack),
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    .drop_count (drop_count),
`endif
    .state_dbg  (state_dbg)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_data"}, data, 8'h00);
    chk({tag, "_dv"}, data_valid, 1'b0);
    chk({tag, "_full"}, full, 1'b0);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_state"}, state_dbg, 2'd0);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    chk({tag, "_dropcnt"}, drop_count, 8'd0);
`endif
  endtask

  // scoreboard side: wait (bounded) for a presented byte and compare to exp_q head
  task automatic recv(input string tag, input int max_wait, output int waited);
    logic [7:0] e;
    waited = 0;
    while (!data_valid && waited < max_wait) begin
      tick();
      waited++;
    end
    chk({tag, "_dv_seen"}, data_valid, 1'b1);
    chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    chk({tag, "_byte"}, data, e);
  endtask

  // model transmitter: ack after a delay, drop ack one cycle after data_valid falls
  task automatic ack(input string tag, input int delay);
    repeat (delay) tick();
    chk({tag, "_data_held"}, data_valid, 1'b1);
    tx_ack = 1'b1;
    tick();
    chk({tag, "_dv_drop"}, data_valid, 1'b0);
    chk({tag, "_release"}, state_dbg, 2'd2);
    tx_ack = 1'b0;
    tick();
    chk({tag, "_idle"}, state_dbg, 2'd0);
  endtask

  initial begin
    // reset
    repeat (3) tick();
    check_reset_vals("rst");
    nrst = 1'b1;
    tick();

    // single byte latency and handshake
    write_byte(8'hA5);
    chk("t1_empty", empty, 1'b0);
    chk("t1_level", level, 1);
    chk("t1_dv_e0", data_valid, 1'b0);
    tick();
    chk("t1_dv_e1", data_valid, 1'b1);
    chk("t1_data", data, 8'hA5);
    chk("t1_level_pop", level, 0);
    chk("t1_busy", busy, 1'b1);
    tx_ack = 1'b1;
    tick();
    chk("t1_dv_drop", data_valid, 1'b0);
    tx_ack = 1'b0;
    tick();
    chk("t1_idle", state_dbg, 2'd0);
    chk("t1_busy_done", busy, 1'b0);

    // three bytes queued while tx_ack holds IDLE, then drained in order
    tx_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      write_byte(8'(i));
      exp_q.push_back(8'(i));
    end
    chk("t2_level3", level, 3);
    chk("t2_no_present", data_valid, 1'b0);
    tx_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      recv("t2", 4, w);
      chk("t2_gap", w, 1);
      chk("t2_level", level, 2 - i);
      ack("t2", 20);
    end
    chk("t2_busy", busy, 1'b0);

    // fill while stalled in PRESENT, overflow, write on pop cycle while full
    write_byte(8'h10);
    exp_q.push_back(8'h10);
    tick();
    for (int i = 0; i < 16; i++) begin
      write_byte(8'h20 + 8'(i));
      exp_q.push_back(8'h20 + 8'(i));
    end
    chk("t3_level16", level, 16);
    chk("t3_full", full, 1'b1);
    chk("t3_ovf_before", overflow, 1'b0);
    write_byte(8'hEE);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_level_sat", level, 16);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    chk("t3_dropcnt", drop_count, 8'd1);
`endif
    recv("t3_first", 1, w);
    ack("t3_first", 2);
    chk("t3_full_idle", full, 1'b1);
    write_byte(8'h30);
    exp_q.push_back(8'h30);
    chk("t3_pop_write_level", level, 16);
    chk("t3_pop_write_full", full, 1'b1);
    chk("t3_pop_write_dv", data_valid, 1'b1);
    for (int i = 0; i < 17; i++) begin
      recv("t3_drain", 4, w);
      ack("t3_drain", 1);
    end
    chk("t3_sb_empty", exp_q.size(), 0);
    repeat (4) tick();
    chk("t3_no_extra", data_valid, 1'b0);
    chk("t3_level0", level, 0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_clr_ovf", overflow, 1'b0);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    chk("t3_clr_dropcnt", drop_count, 8'd0);
`endif

    // flush with a write while a byte is in flight
    write_byte(8'h40);
    exp_q.push_back(8'h40);
    tick();
    for (int i = 1; i <= 5; i++) write_byte(8'h40 + 8'(i));
    chk("t4_level5", level, 5);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h99;
    tick();
    flush   = 1'b0;
    wr_en   = 1'b0;
    chk("t4_level0", level, 0);
    chk("t4_empty", empty, 1'b1);
    chk("t4_ovf", overflow, 1'b0);
    recv("t4_inflight", 1, w);
    ack("t4_inflight", 3);
    repeat (5) tick();
    chk("t4_no_more", data_valid, 1'b0);
    chk("t4_busy", busy, 1'b0);

    // reset mid-handshake with tx_ack held high
    write_byte(8'h50);
    tick();
    for (int i = 0; i < 16; i++) write_byte(8'h60 + 8'(i));
    write_byte(8'hEE);
    chk("t5_pre_ovf", overflow, 1'b1);
    chk("t5_pre_dv", data_valid, 1'b1);
    nrst   = 1'b0;
    tx_ack = 1'b1;
    tick();
    check_reset_vals("t5_rst");
    nrst = 1'b1;
    write_byte(8'h52);
    exp_q.push_back(8'h52);
    repeat (3) tick();
    chk("t5_wait_state", state_dbg, 2'd0);
    chk("t5_wait_dv", data_valid, 1'b0);
    chk("t5_wait_level", level, 1);
    tx_ack = 1'b0;
    recv("t5_after", 2, w);
    chk("t5_after_wait", w, 1);
    ack("t5_after", 1);

    // many dropped writes, then clear; drop and clear together keeps the flag
    write_byte(8'h70);
    exp_q.push_back(8'h70);
    tick();
    for (int i = 0; i < 16; i++) write_byte(8'h71 + 8'(i));
    wr_en   = 1'b1;
    wr_data = 8'hDD;
    repeat (300) tick();
    wr_en = 1'b0;
    chk("t6_ovf", overflow, 1'b1);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    chk("t6_dropcnt_sat", drop_count, 8'd255);
`endif
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t6_clr_ovf", overflow, 1'b0);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    chk("t6_clr_dropcnt", drop_count, 8'd0);
`endif
    wr_en   = 1'b1;
    clr_ovf = 1'b1;
    tick();
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    chk("t6_set_wins", overflow, 1'b1);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    chk("t6_inc_wins", drop_count, 8'd1);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    recv("t6_inflight", 1, w);
    ack("t6_inflight", 1);
    tick();
    chk("t6_busy", busy, 1'b0);
    chk("t6_sb_empty", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
